sfm_row_sequencer: RTL and testbench
====================================

# sfm_row_sequencer

Multi-row job sequencer for the softmax accelerator. It accepts one matrix-level softmax job: base addresses, per-row byte length, row strides and row count. It splits the job into per-row softmax jobs, presented one at a time to the softmax control FSM as address/length/start. The block sits between the configuration path and the softmax controller and raises a single completion pulse when all rows are finished.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of base addresses, strides and row addresses.
- CNT_WIDTH, 16, width of row count and row counter.
- DATA_WIDTH, 128, streamer data width in bits; row length must be a multiple of DATA_WIDTH/8 bytes.

Ports:
- clk_i  in  1  clock; one clock domain only.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear, same effect as reset.
- cfg_valid_i  in  1  job descriptor valid.
- cfg_ready_o  out  1  job descriptor accepted when valid & ready.
- cfg_in_base_i  in  ADDR_WIDTH  input base address for row 0.
- cfg_out_base_i  in  ADDR_WIDTH  output base address for row 0.
- cfg_in_stride_i  in  ADDR_WIDTH  byte stride between input rows.
- cfg_out_stride_i  in  ADDR_WIDTH  byte stride between output rows.
- cfg_row_len_i  in  32  row length in bytes.
- cfg_n_rows_i  in  CNT_WIDTH  number of rows.
- row_start_o  out  1  single-cycle start pulse to the softmax controller.
- row_in_addr_o  out  ADDR_WIDTH  current row input address.
- row_out_addr_o  out  ADDR_WIDTH  current row output address.
- row_len_o  out  32  current row length in bytes.
- row_busy_i  in  1  softmax controller busy.
- row_done_i  in  1  single-cycle pulse when the softmax controller finishes a row.
- busy_o  out  1  job in progress.
- done_o  out  1  single-cycle job-completion pulse.
- err_o  out  1  single-cycle pulse when a descriptor is rejected.
- rows_done_o  out  CNT_WIDTH  rows completed in the current or last job.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ROW, FINISH.
- IDLE:
  - cfg_ready_o=1; busy_o=0.
  - On accept, register all descriptor fields and clear rows_done_o.
  - If cfg_row_len_i==0 or cfg_row_len_i mod (DATA_WIDTH/8)≠0, go to FINISH with error.
  - Else if cfg_n_rows_i==0, go to FINISH without error.
  - Otherwise go to ISSUE.
- ISSUE:
  - Wait while row_busy_i=1.
  - When row_busy_i=0, assert row_start_o for exactly that cycle, then go to WAIT_ROW.
- WAIT_ROW:
  - On row_done_i, increment rows_done_o.
  - If the new count equals n_rows, go to FINISH.
  - Otherwise in_addr += in_stride and out_addr += out_stride, then go to ISSUE.
- FINISH:
  - done_o=1 for one cycle; err_o=1 in the same cycle if the descriptor was rejected.
  - Then go to IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; overflow wraps silently.
- row_in_addr_o, row_out_addr_o and row_len_o come straight from registers. They are stable from the row_start_o cycle until the next address update.
- row_done_i outside WAIT_ROW is ignored. A row_done_i coincident with row_start_o is ignored.
- cfg_valid_i outside IDLE is not accepted (cfg_ready_o=0); the descriptor inputs are don't-care there.
- rows_done_o holds its final value in IDLE until the next accept.
- clear_i and reset:
  - All registers return to reset values and the FSM returns to IDLE.
  - No done_o or err_o is produced; an in-flight row is abandoned.
  - clear_i has priority over every other event in the same cycle.

## Timing
- Reset values:
  - cfg_ready_o=1 (IDLE).
  - All other outputs 0: row_start_o, busy_o, done_o, err_o, rows_done_o, row_in_addr_o, row_out_addr_o, row_len_o.
- busy_o=1 in ISSUE, WAIT_ROW and FINISH.
- Accept cycle T: ISSUE at T+1. row_start_o at T+1 if row_busy_i=0, otherwise in the first cycle after row_busy_i falls.
- row_done_i at cycle D (not the last row): addresses update at D+1 and row_start_o pulses at D+1 if row_busy_i=0.
- Last row_done_i at D: done_o at D+1; IDLE with cfg_ready_o=1 at D+2.
- Rejected or zero-row descriptor accepted at T: done_o (plus err_o if rejected) at T+1; cfg_ready_o=1 at T+2.
- Back-to-back jobs: a new descriptor is acceptable at D+2, giving its first row_start_o no earlier than D+3.

## Test plan
- 3 rows; in_base=0x1000, out_base=0x8000, strides 0x200, row_len=0x100; row_done_i 10 cycles after each start. Required: starts at 0x1000/0x8000, 0x1200/0x8200, 0x1400/0x8400; one done_o one cycle after the 3rd row_done_i; rows_done_o=3.
- row_len=0x104 (not a multiple of 16): no row_start_o; done_o and err_o together one cycle after accept. n_rows=0: done_o one cycle after accept, err_o=0.
- row_busy_i held high 5 cycles after accept: row_start_o delayed until the first cycle with row_busy_i=0; exactly one start pulse.
- in_base=0xFFFFFF00, in_stride=0x100, 2 rows: second row_in_addr_o=0x00000000 (wraparound).
- Spurious row_done_i in IDLE and ISSUE: ignored, counter unchanged. clear_i mid-WAIT_ROW of row 2: back to IDLE next cycle, all outputs 0, no done_o.
- rst_ni asserted asynchronously mid-job: outputs go to reset values immediately. A new job issued after release completes normally.

Source files
------------

// File: rtl/sfm_row_sequencer.sv
// Splits a matrix softmax job into per-row address/length/start requests for the softmax controller.
// First row_start_o one cycle after accept; waits on row_busy_i before each start; cfg_ready_o only in IDLE.
module sfm_row_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [ADDR_WIDTH-1:0] cfg_in_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_out_base_i,
    input  logic [ADDR_WIDTH-1:0] cfg_in_stride_i,
    input  logic [ADDR_WIDTH-1:0] cfg_out_stride_i,
    input  logic [31:0]           cfg_row_len_i,
    input  logic [CNT_WIDTH-1:0]  cfg_n_rows_i,
    output logic                  row_start_o,
    output logic [ADDR_WIDTH-1:0] row_in_addr_o,
    output logic [ADDR_WIDTH-1:0] row_out_addr_o,
    output logic [31:0]           row_len_o,
    input  logic                  row_busy_i,
    input  logic                  row_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  rows_done_o
);

    localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ROW,
        FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [ADDR_WIDTH-1:0] in_stride_q, in_stride_d;
    logic [ADDR_WIDTH-1:0] out_stride_q, out_stride_d;
    logic [31:0]           row_len_q, row_len_d;
    logic [CNT_WIDTH-1:0]  n_rows_q, n_rows_d;
    logic [CNT_WIDTH-1:0]  rows_done_q, rows_done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  len_bad;
    logic [CNT_WIDTH-1:0]  rows_done_inc;

    // clear_i blocks the handshake so a descriptor is never taken in a clear cycle
    assign cfg_ready_o   = (state_q == IDLE) && !clear_i;
    assign accept        = cfg_valid_i && cfg_ready_o;
    assign len_bad       = (cfg_row_len_i == 32'd0) || ((cfg_row_len_i % BEAT_BYTES) != 32'd0);
    assign rows_done_inc = rows_done_q + 1'b1;

    assign row_in_addr_o  = in_addr_q;
    assign row_out_addr_o = out_addr_q;
    assign row_len_o      = row_len_q;
    assign rows_done_o    = rows_done_q;
    assign busy_o         = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        in_addr_d    = in_addr_q;
        out_addr_d   = out_addr_q;
        in_stride_d  = in_stride_q;
        out_stride_d = out_stride_q;
        row_len_d    = row_len_q;
        n_rows_d     = n_rows_q;
        rows_done_d  = rows_done_q;
        err_d        = err_q;
        row_start_o  = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    in_addr_d    = cfg_in_base_i;
                    out_addr_d   = cfg_out_base_i;
                    in_stride_d  = cfg_in_stride_i;
                    out_stride_d = cfg_out_stride_i;
                    row_len_d    = cfg_row_len_i;
                    n_rows_d     = cfg_n_rows_i;
                    rows_done_d  = '0;
                    err_d        = len_bad;
                    if (len_bad || (cfg_n_rows_i == '0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!row_busy_i) begin
                    row_start_o = 1'b1;
                    state_d     = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (row_done_i) begin
                    rows_done_d = rows_done_inc;
                    if (rows_done_inc == n_rows_q) begin
                        state_d = FINISH;
                    end else begin
                        in_addr_d  = in_addr_q + in_stride_q;
                        out_addr_d = out_addr_q + out_stride_q;
                        state_d    = ISSUE;
                    end
                end
            end
            FINISH: begin
                done_o  = 1'b1;
                err_o   = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Soft clear wins over everything, including pulses already decoded this cycle
        if (clear_i) begin
            state_d      = IDLE;
            in_addr_d    = '0;
            out_addr_d   = '0;
            in_stride_d  = '0;
            out_stride_d = '0;
            row_len_d    = '0;
            n_rows_d     = '0;
            rows_done_d  = '0;
            err_d        = 1'b0;
            row_start_o  = 1'b0;
            done_o       = 1'b0;
            err_o        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            row_len_q    <= '0;
            n_rows_q     <= '0;
            rows_done_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_addr_q    <= in_addr_d;
            out_addr_q   <= out_addr_d;
            in_stride_q  <= in_stride_d;
            out_stride_q <= out_stride_d;
            row_len_q    <= row_len_d;
            n_rows_q     <= n_rows_d;
            rows_done_q  <= rows_done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_sfm_row_sequencer.sv
// Directed bench for sfm_row_sequencer: multi-row jobs, rejects, busy stall, wrap, clear and async reset.
module tb_sfm_row_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_in_base, cfg_out_base, cfg_in_stride, cfg_out_stride;
    logic [31:0] cfg_row_len;
    logic [15:0] cfg_n_rows;
    logic        row_start;
    logic [31:0] row_in_addr, row_out_addr, row_len;
    logic        row_busy, row_done;
    logic        busy, done, err;
    logic [15:0] rows_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_done = 0;
    int base_start, base_done;
    logic saw;

    always #5 clk = ~clk;

    sfm_row_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_in_base_i   (cfg_in_base),
        .cfg_out_base_i  (cfg_out_base),
        .cfg_in_stride_i (cfg_in_stride),
        .cfg_out_stride_i(cfg_out_stride),
        .cfg_row_len_i   (cfg_row_len),
        .cfg_n_rows_i    (cfg_n_rows),
        .row_start_o     (row_start),
        .row_in_addr_o   (row_in_addr),
        .row_out_addr_o  (row_out_addr),
        .row_len_o       (row_len),
        .row_busy_i      (row_busy),
        .row_done_i      (row_done),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .rows_done_o     (rows_done)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (row_start) n_start++;
            if (done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Presents one descriptor for a single cycle; returns at the start of the cycle after accept
    task automatic send_job(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] is,
                            input logic [31:0] os, input logic [31:0] len, input logic [15:0] n);
        tick();
        cfg_valid      = 1'b1;
        cfg_in_base    = ib;
        cfg_out_base   = ob;
        cfg_in_stride  = is;
        cfg_out_stride = os;
        cfg_row_len    = len;
        cfg_n_rows     = n;
        smp();
        chk("accept_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    // From the row_start sample point: row_done_i 'gap' cycles later, returns at the sample of the next cycle
    task automatic finish_row(input int gap);
        repeat (gap) tick();
        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        smp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; cfg_valid = 1'b0;
        cfg_in_base = '0; cfg_out_base = '0; cfg_in_stride = '0; cfg_out_stride = '0;
        cfg_row_len = '0; cfg_n_rows = '0; row_busy = 1'b0; row_done = 1'b0;

        repeat (2) @(posedge clk);
        smp();
        chk("rst_ready", cfg_ready, 1);
        chk("rst_start", row_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rows", rows_done, 0);
        chk("rst_in", row_in_addr, 0);
        chk("rst_out", row_out_addr, 0);
        chk("rst_len", row_len, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Three rows, row_done 10 cycles after each start
        base_start = n_start; base_done = n_done;
        send_job(32'h1000, 32'h8000, 32'h200, 32'h200, 32'h100, 16'd3);
        smp();
        chk("j1_start0", row_start, 1);
        chk("j1_in0", row_in_addr, 32'h1000);
        chk("j1_out0", row_out_addr, 32'h8000);
        chk("j1_len", row_len, 32'h100);
        chk("j1_busy", busy, 1);
        for (int r = 0; r < 3; r++) begin
            finish_row(10);
            if (r < 2) begin
                chk("j1_start", row_start, 1);
                chk("j1_in", row_in_addr, 32'h1000 + 32'h200 * (r + 1));
                chk("j1_out", row_out_addr, 32'h8000 + 32'h200 * (r + 1));
                chk("j1_rows", rows_done, r + 1);
            end else begin
                chk("j1_done", done, 1);
                chk("j1_err", err, 0);
                chk("j1_rows_final", rows_done, 3);
            end
        end
        tick(); smp();
        chk("j1_idle_ready", cfg_ready, 1);
        chk("j1_idle_busy", busy, 0);
        chk("j1_done_gone", done, 0);
        chk("j1_n_done", n_done - base_done, 1);
        chk("j1_n_start", n_start - base_start, 3);

        // Spurious row_done in IDLE
        tick(); row_done = 1'b1;
        tick(); row_done = 1'b0;
        smp();
        chk("idle_spur_rows", rows_done, 3);

        // Bad length: 0x104 is not a multiple of 16
        base_start = n_start;
        send_job(32'h1000, 32'h8000, 32'h200, 32'h200, 32'h104, 16'd2);
        smp();
        chk("rej_done", done, 1);
        chk("rej_err", err, 1);
        chk("rej_rows", rows_done, 0);
        tick(); smp();
        chk("rej_ready", cfg_ready, 1);
        chk("rej_err_gone", err, 0);
        chk("rej_no_start", n_start - base_start, 0);

        // Zero rows
        send_job(32'h1000, 32'h8000, 32'h200, 32'h200, 32'h100, 16'd0);
        smp();
        chk("zero_done", done, 1);
        chk("zero_err", err, 0);
        tick(); smp();
        chk("zero_ready", cfg_ready, 1);
        chk("zero_no_start", n_start - base_start, 0);

        // row_busy_i held for 5 cycles after accept, spurious row_done in ISSUE
        base_start = n_start;
        row_busy = 1'b1;
        send_job(32'h2000, 32'h9000, 32'h100, 32'h100, 32'h40, 16'd1);
        saw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            smp();
            saw |= row_start;
            tick();
            row_done = (k == 1);
            if (k == 5) row_busy = 1'b0;
        end
        smp();
        chk("bsy_no_early_start", saw, 0);
        chk("bsy_start", row_start, 1);
        chk("bsy_rows_spur", rows_done, 0);
        finish_row(3);
        chk("bsy_done", done, 1);
        chk("bsy_rows", rows_done, 1);
        chk("bsy_one_start", n_start - base_start, 1);

        // Address wraparound; descriptor sent back-to-back at D+2
        send_job(32'hFFFF_FF00, 32'h0, 32'h100, 32'h40, 32'h10, 16'd2);
        smp();
        chk("wrap_start0", row_start, 1);
        chk("wrap_in0", row_in_addr, 32'hFFFF_FF00);
        finish_row(2);
        chk("wrap_start1", row_start, 1);
        chk("wrap_in1", row_in_addr, 32'h0);
        chk("wrap_out1", row_out_addr, 32'h40);
        finish_row(2);
        chk("wrap_done", done, 1);

        // clear_i during WAIT_ROW of row 2
        send_job(32'h3000, 32'hA000, 32'h80, 32'h80, 32'h20, 16'd3);
        smp();
        finish_row(4);
        chk("clr_row2_in", row_in_addr, 32'h3080);
        repeat (3) tick();
        base_done = n_done;
        clear = 1'b1;
        smp();
        chk("clr_no_done", done, 0);
        tick(); clear = 1'b0;
        smp();
        chk("clr_ready", cfg_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_in", row_in_addr, 0);
        chk("clr_out", row_out_addr, 0);
        chk("clr_len", row_len, 0);
        chk("clr_rows", rows_done, 0);
        tick(); row_done = 1'b1;
        tick(); row_done = 1'b0;
        smp();
        chk("clr_late_done_rows", rows_done, 0);
        chk("clr_no_done_pulse", n_done - base_done, 0);

        // Asynchronous reset mid-job, then a fresh job
        send_job(32'h4000, 32'hB000, 32'h40, 32'h40, 32'h30, 16'd2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_in", row_in_addr, 0);
        chk("arst_len", row_len, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send_job(32'h5000, 32'hC000, 32'h40, 32'h40, 32'h30, 16'd1);
        smp();
        chk("post_start", row_start, 1);
        chk("post_in", row_in_addr, 32'h5000);
        finish_row(5);
        chk("post_done", done, 1);
        chk("post_rows", rows_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
